regbank_port_ctrl: RTL and testbench
====================================

Name: regbank_port_ctrl

Overview:
- Client-side controller for the two-address register bank (32 x 32-bit, one registered read of both addresses per enabled read edge, one write edge per enabled write).
- Accepts operand-read requests from decode and write-back requests from the WB stage.
- Arbitrates the two request types onto the single bank control interface.
- Enforces the bank's one-cycle read latency and returns both operands through a valid/ready response.
- Makes register 0 read as zero and ignore writes.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high reset
- rd_valid  in  1  operand-read request valid
- rd_ready  out  1  read request accepted this cycle
- rd_addr_a  in  ADDR_W  first source register
- rd_addr_b  in  ADDR_W  second source register
- resp_valid  out  1  operands valid
- resp_ready  in  1  consumer takes operands
- op_a  out  DATA_W  value of rd_addr_a
- op_b  out  DATA_W  value of rd_addr_b
- wb_valid  in  1  write-back request valid
- wb_ready  out  1  write-back accepted this cycle
- wb_addr  in  ADDR_W  destination register
- wb_data  in  DATA_W  write data
- bank_address  out  ADDR_W  bank address port A
- bank_addressB  out  ADDR_W  bank address port B
- bank_enable_write  out  1  bank write strobe
- bank_enable_read  out  1  bank read strobe
- bank_in_data  out  DATA_W  bank write data A
- bank_in_dataB  out  DATA_W  bank write data B
- bank_out_data  in  DATA_W  bank read data A
- bank_out_dataB  in  DATA_W  bank read data B

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high on `reset`.
- Reset values:
  - State = IDLE.
  - rd_ready, wb_ready, resp_valid, bank_enable_write and bank_enable_read = 0.
  - op_a, op_b, bank address and bank data outputs = 0.
  - wr_last flag = 0.
- FSM states: IDLE, RD_WAIT, RESP.
- IDLE, arbitration when both rd_valid and wb_valid are high:
  - Write wins, unless wr_last=1, in which case read wins.
  - wr_last is set on each granted write and cleared on each granted read. This guarantees the read is served within 2 cycles.
- IDLE, write grant:
  - wb_ready=1 combinationally.
  - If wb_addr != 0: bank_enable_write=1, both bank addresses = wb_addr, both bank data = wb_data (identical writes, so there is no port conflict).
  - If wb_addr == 0: the write is acknowledged but bank_enable_write stays 0.
  - Remain in IDLE.
- IDLE, read grant:
  - rd_ready=1, bank_enable_read=1, bank_address = rd_addr_a, bank_addressB = rd_addr_b.
  - Capture both addresses in internal registers.
  - Go to RD_WAIT.
- RD_WAIT:
  - Bank strobes are 0; rd_ready and wb_ready are 0.
  - Bank output is valid this cycle. Register op_a = (addr_a==0) ? 0 : bank_out_data, and likewise op_b from bank_out_dataB.
  - Go to RESP.
- RESP:
  - resp_valid=1; op_a and op_b are held stable until the handshake.
  - On resp_ready=1, go to IDLE with resp_valid=0 the next cycle.
  - rd_ready and wb_ready are 0 throughout.
- Latency:
  - Read accepted in cycle N gives resp_valid in cycle N+2.
  - Minimum read-to-read spacing is 3 cycles.
  - A write accepted in cycle N is visible to a read accepted in cycle N+1 or later; no forwarding is required.
- Strobe exclusivity: bank_enable_write and bank_enable_read are never both 1.
- No write may occur between a granted read and its response.
- Requests not granted simply wait. Inputs must stay stable while valid is high without ready.
- rd_addr_a == rd_addr_b is legal and returns the same value on both operands.
- Reset in RD_WAIT or RESP: the pending response is discarded, resp_valid=0 next cycle, state = IDLE.

Decomposition:
- Shared package regbank_pkg holds:
  - DATA_W and ADDR_W defaults.
  - REG_ZERO = 0.
  - The state encoding IDLE=2'd0, RD_WAIT=2'd1, RESP=2'd2.
- No sub-module is needed. The arbiter and FSM live in one always block, with a combinational strobe/address mux.
- The bench instantiates the existing bank behind this block.

Test Plan:
1. Read of reg 0 (reset contents unknown), addr_a=0, addr_b=0 -> resp_valid in cycle N+2, op_a=op_b=0.
2. Write reg 5 = 0xDEADBEEF in cycle N, read (5,5) in cycle N+1 -> bank_enable_write=1 in cycle N only; op_a=op_b=0xDEADBEEF at N+3.
3. Write reg 0 = 0x12345678, then read (0,3) after reg 3 = 0x0000_00A5 -> bank_enable_write stays 0 for the reg 0 write; op_a=0, op_b=0xA5.
4. rd_valid and wb_valid held high with back-to-back writes -> grants alternate W, R, (RD_WAIT, RESP), W. The read is granted the cycle after the first write, and the strobes are never both high.
5. resp_ready held 0 for 4 cycles in RESP, with a write pending -> op_a/op_b stable, wb_ready=0 until the handshake, then the write is granted in the first IDLE cycle.
6. reset asserted in RD_WAIT -> next cycle state IDLE, resp_valid=0, op_a=op_b=0, all strobes 0.

Source files
------------

// File: rtl/regbank_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regbank_pkg
//  Brief    : Shared widths, zero-register index and controller state codes
//             for the register-bank port controller.
//  Revision : 1.0 - initial release
// ============================================================================
package regbank_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Architectural zero register: reads as zero, writes are dropped.
  localparam int REG_ZERO   = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

endpackage : regbank_pkg
`default_nettype wire

// File: rtl/regbank_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : regbank_port_ctrl
//  Brief    : Client-side controller for a two-address, one-cycle-latency
//             register bank. Arbitrates operand reads against write-backs,
//             returns both operands through a valid/ready response and
//             hides register 0 (reads zero, ignores writes).
//  Revision : 1.0 - initial release
// ============================================================================
module regbank_port_ctrl
  import regbank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  // Operand-read request from decode
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  // Operand response
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  // Write-back request
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  // Bank control interface
  output logic [ADDR_W-1:0] bank_address,
  output logic [ADDR_W-1:0] bank_addressB,
  output logic              bank_enable_write,
  output logic              bank_enable_read,
  output logic [DATA_W-1:0] bank_in_data,
  output logic [DATA_W-1:0] bank_in_dataB,
  input  logic [DATA_W-1:0] bank_out_data,
  input  logic [DATA_W-1:0] bank_out_dataB
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  state_t            state_q;
  logic              wr_last_q;
  logic [ADDR_W-1:0] addr_a_q;
  logic [ADDR_W-1:0] addr_b_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;

  logic              grant_w;
  logic              grant_r;

  // Arbitration: only in IDLE; write wins unless the previous grant was a
  // write, which bounds a contending read's wait to one extra cycle.
  always_comb begin
    grant_w = 1'b0;
    grant_r = 1'b0;
    if (!reset && (state_q == IDLE)) begin
      if (wb_valid && (!rd_valid || !wr_last_q)) begin
        grant_w = 1'b1;
      end else if (rd_valid) begin
        grant_r = 1'b1;
      end
    end
  end

  // Bank strobe/address mux; a write drives identical address and data on
  // both ports so the two write ports never disagree.
  always_comb begin
    bank_address      = '0;
    bank_addressB     = '0;
    bank_in_data      = '0;
    bank_in_dataB     = '0;
    bank_enable_write = 1'b0;
    bank_enable_read  = 1'b0;
    if (grant_w) begin
      bank_address      = wb_addr;
      bank_addressB     = wb_addr;
      bank_in_data      = wb_data;
      bank_in_dataB     = wb_data;
      bank_enable_write = (wb_addr != ZERO_ADDR);
    end else if (grant_r) begin
      bank_address      = rd_addr_a;
      bank_addressB     = rd_addr_b;
      bank_enable_read  = 1'b1;
    end
  end

  // Controller FSM: read grant -> wait one cycle for bank data -> hold the
  // response until the consumer takes it. Writes never leave IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_last_q <= 1'b0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_w) begin
            wr_last_q <= 1'b1;
          end else if (grant_r) begin
            wr_last_q <= 1'b0;
            addr_a_q  <= rd_addr_a;
            addr_b_q  <= rd_addr_b;
            state_q   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          op_a_q  <= (addr_a_q == ZERO_ADDR) ? '0 : bank_out_data;
          op_b_q  <= (addr_b_q == ZERO_ADDR) ? '0 : bank_out_dataB;
          state_q <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rd_ready   = grant_r;
  assign wb_ready   = grant_w;
  assign resp_valid = (state_q == RESP);
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;

endmodule : regbank_port_ctrl
`default_nettype wire

// File: tb/tb_regbank_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regbank_port_ctrl
//  Brief    : Directed self-checking bench for regbank_port_ctrl with a
//             behavioural 32 x 32-bit two-address bank behind it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regbank_port_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        rd_valid, rd_ready;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic        resp_valid, resp_ready;
  logic [31:0] op_a, op_b;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  bank_address, bank_addressB;
  logic        bank_enable_write, bank_enable_read;
  logic [31:0] bank_in_data, bank_in_dataB;
  logic [31:0] bank_out_data, bank_out_dataB;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  regbank_port_ctrl #(.DATA_W(32), .ADDR_W(5)) dut (
    .clock(clock), .reset(reset),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .op_a(op_a), .op_b(op_b),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .bank_address(bank_address), .bank_addressB(bank_addressB),
    .bank_enable_write(bank_enable_write), .bank_enable_read(bank_enable_read),
    .bank_in_data(bank_in_data), .bank_in_dataB(bank_in_dataB),
    .bank_out_data(bank_out_data), .bank_out_dataB(bank_out_dataB)
  );

  // Behavioural bank: registered two-address read, dual write port.
  // Contents start as non-zero garbage so a missing zero-register mask shows.
  logic [31:0] mem [32];
  logic        init_done = 1'b0;
  always @(posedge clock) begin
    if (!init_done) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hBAD0_0000 | 32'(i);
      init_done <= 1'b1;
    end else begin
      if (bank_enable_write) begin
        mem[bank_address]  <= bank_in_data;
        mem[bank_addressB] <= bank_in_dataB;
      end
      if (bank_enable_read) begin
        bank_out_data  <= mem[bank_address];
        bank_out_dataB <= mem[bank_addressB];
      end
    end
  end

  // Strobe exclusivity watched on every cycle
  always @(negedge clock) begin
    if (!reset && init_done) begin
      checks++;
      if (bank_enable_write && bank_enable_read) begin
        errors++;
        $display("FAIL strobe_excl: write=%0b read=%0b, required not both 1", bank_enable_write, bank_enable_read);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; rd_valid = 0; rd_addr_a = 0; rd_addr_b = 0; resp_ready = 1;
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({rd_ready, wb_ready, resp_valid, bank_enable_write, bank_enable_read} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rd_rdy/wb_rdy/resp_v/en_w/en_r=%b, required 00000",
               {rd_ready, wb_ready, resp_valid, bank_enable_write, bank_enable_read});
    end
    checks++;
    if ({op_a, op_b, bank_address, bank_addressB, bank_in_data, bank_in_dataB} !== '0) begin
      errors++;
      $display("FAIL reset_data: op_a=%h op_b=%h addr=%h/%h din=%h/%h, required all 0",
               op_a, op_b, bank_address, bank_addressB, bank_in_data, bank_in_dataB);
    end
    tick();
  endtask

  // Read (0,0): contents of reg 0 in the bank are garbage, must return zero.
  task automatic test_read_zero();
    rd_valid = 1; rd_addr_a = 0; rd_addr_b = 0;
    @(negedge clock);
    checks++;
    if ({rd_ready, bank_enable_read} !== 2'b11) begin
      errors++; $display("FAIL rz_grant: rd_ready/en_r=%b, required 11", {rd_ready, bank_enable_read});
    end
    tick(); rd_valid = 0;
    @(negedge clock);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL rz_n1: resp_valid=%b, required 0", resp_valid);
    end
    tick();
    @(negedge clock);
    checks++;
    if ({resp_valid, op_a, op_b} !== {1'b1, 64'h0}) begin
      errors++; $display("FAIL rz_n2: resp_valid=%b op_a=%h op_b=%h, required 1 0 0", resp_valid, op_a, op_b);
    end
    tick();
    @(negedge clock);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL rz_done: resp_valid=%b, required 0", resp_valid);
    end
  endtask

  // Write reg 5 then read (5,5) the very next cycle.
  task automatic test_write_then_read();
    wb_valid = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
    @(negedge clock);
    checks++;
    if ({wb_ready, bank_enable_write, bank_address, bank_addressB, bank_in_data} !== {2'b11, 5'd5, 5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL wr5_grant: wb_rdy=%b en_w=%b addr=%0d/%0d din=%h, required 1 1 5/5 deadbeef",
                         wb_ready, bank_enable_write, bank_address, bank_addressB, bank_in_data);
    end
    tick(); wb_valid = 0; rd_valid = 1; rd_addr_a = 5; rd_addr_b = 5;
    @(negedge clock);
    checks++;
    if ({bank_enable_write, rd_ready} !== 2'b01) begin
      errors++; $display("FAIL wr5_n1: en_w=%b rd_ready=%b, required 0 1", bank_enable_write, rd_ready);
    end
    tick(); rd_valid = 0;
    tick();
    @(negedge clock);
    checks++;
    if ({resp_valid, op_a, op_b} !== {1'b1, 32'hDEADBEEF, 32'hDEADBEEF}) begin
      errors++; $display("FAIL wr5_resp: resp_valid=%b op_a=%h op_b=%h, required 1 deadbeef deadbeef", resp_valid, op_a, op_b);
    end
    tick();
  endtask

  // Write reg 3, write reg 0 (must be dropped), read (0,3).
  task automatic test_reg_zero_write();
    wb_valid = 1; wb_addr = 3; wb_data = 32'h0000_00A5;
    tick();
    wb_addr = 0; wb_data = 32'h1234_5678;
    @(negedge clock);
    checks++;
    if ({wb_ready, bank_enable_write} !== 2'b10) begin
      errors++; $display("FAIL wr0_strobe: wb_ready=%b en_w=%b, required 1 0", wb_ready, bank_enable_write);
    end
    tick(); wb_valid = 0; rd_valid = 1; rd_addr_a = 0; rd_addr_b = 3;
    tick(); rd_valid = 0;
    tick();
    @(negedge clock);
    checks++;
    if ({resp_valid, op_a, op_b} !== {1'b1, 32'h0, 32'h0000_00A5}) begin
      errors++; $display("FAIL rd03_resp: resp_valid=%b op_a=%h op_b=%h, required 1 0 a5", resp_valid, op_a, op_b);
    end
    tick();
  endtask

  // Both requests held: W, R, (RD_WAIT, RESP), W, then the still-pending R.
  task automatic test_back_to_back();
    wb_valid = 1; wb_addr = 7; wb_data = 32'h1111_1111;
    rd_valid = 1; rd_addr_a = 7; rd_addr_b = 7;
    @(negedge clock);
    checks++;
    if ({wb_ready, rd_ready} !== 2'b10) begin
      errors++; $display("FAIL b2b_c1: wb_ready/rd_ready=%b, required 10", {wb_ready, rd_ready});
    end
    tick(); wb_addr = 8; wb_data = 32'h2222_2222;
    @(negedge clock);
    checks++;
    if ({wb_ready, rd_ready} !== 2'b01) begin
      errors++; $display("FAIL b2b_c2: wb_ready/rd_ready=%b, required 01", {wb_ready, rd_ready});
    end
    tick();
    @(negedge clock);
    checks++;
    if ({wb_ready, rd_ready, resp_valid} !== 3'b000) begin
      errors++; $display("FAIL b2b_c3: wb_rdy/rd_rdy/resp_v=%b, required 000", {wb_ready, rd_ready, resp_valid});
    end
    tick();
    @(negedge clock);
    checks++;
    if ({wb_ready, rd_ready, resp_valid, op_a} !== {3'b001, 32'h1111_1111}) begin
      errors++; $display("FAIL b2b_c4: wb_rdy/rd_rdy/resp_v=%b op_a=%h, required 001 11111111",
                         {wb_ready, rd_ready, resp_valid}, op_a);
    end
    tick();
    @(negedge clock);
    checks++;
    if ({wb_ready, rd_ready, bank_enable_write} !== 3'b101) begin
      errors++; $display("FAIL b2b_c5: wb_rdy/rd_rdy/en_w=%b, required 101", {wb_ready, rd_ready, bank_enable_write});
    end
    tick(); wb_valid = 0;
    @(negedge clock);
    checks++;
    if (rd_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_c6: rd_ready=%b, required 1", rd_ready);
    end
    tick(); rd_valid = 0;
    tick(); tick();
  endtask

  // Stalled response with a write waiting behind it.
  task automatic test_resp_stall();
    resp_ready = 0; rd_valid = 1; rd_addr_a = 5; rd_addr_b = 3;
    tick(); rd_valid = 0; wb_valid = 1; wb_addr = 9; wb_data = 32'h0000_0099;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if ({resp_valid, wb_ready, bank_enable_write, op_a, op_b} !== {3'b100, 32'hDEADBEEF, 32'h0000_00A5}) begin
        errors++; $display("FAIL stall_%0d: resp_v/wb_rdy/en_w=%b op_a=%h op_b=%h, required 100 deadbeef a5",
                           i, {resp_valid, wb_ready, bank_enable_write}, op_a, op_b);
      end
      tick();
    end
    resp_ready = 1;
    @(negedge clock);
    checks++;
    if ({resp_valid, wb_ready} !== 2'b10) begin
      errors++; $display("FAIL stall_hs: resp_valid/wb_ready=%b, required 10", {resp_valid, wb_ready});
    end
    tick();
    @(negedge clock);
    checks++;
    if ({resp_valid, wb_ready, bank_enable_write, bank_address} !== {3'b011, 5'd9}) begin
      errors++; $display("FAIL stall_wb: resp_v/wb_rdy/en_w=%b addr=%0d, required 011 9",
                         {resp_valid, wb_ready, bank_enable_write}, bank_address);
    end
    tick(); wb_valid = 0;
  endtask

  // Reset landing while the controller waits on bank data.
  task automatic test_reset_rd_wait();
    rd_valid = 1; rd_addr_a = 5; rd_addr_b = 5;
    tick(); rd_valid = 0; reset = 1;
    tick(); reset = 0;
    @(negedge clock);
    checks++;
    if ({resp_valid, bank_enable_write, bank_enable_read, rd_ready, wb_ready, op_a, op_b} !== '0) begin
      errors++; $display("FAIL rst_rdwait: resp_v=%b en_w=%b en_r=%b op_a=%h op_b=%h, required all 0",
                         resp_valid, bank_enable_write, bank_enable_read, op_a, op_b);
    end
    tick();
    rd_valid = 1; rd_addr_a = 3; rd_addr_b = 3;
    @(negedge clock);
    checks++;
    if (rd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_idle: rd_ready=%b, required 1 (controller back in IDLE)", rd_ready);
    end
    tick(); rd_valid = 0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_read_zero();
    test_write_then_read();
    test_reg_zero_write();
    test_back_to_back();
    test_resp_stall();
    test_reset_rd_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_regbank_port_ctrl
`default_nettype wire
